// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants for the openMIPS ID stage: opcodes, funct codes,
// aluop/alusel encodings and enable levels.
package id_stage_fwd_pkg;

   localparam logic [5:0] EXE_ORI     = 6'b001101;
   localparam logic [5:0] EXE_ANDI    = 6'b001100;
   localparam logic [5:0] EXE_XORI    = 6'b001110;
   localparam logic [5:0] EXE_LUI     = 6'b001111;
   localparam logic [5:0] EXE_SPECIAL = 6'b000000;

   localparam logic [5:0] EXE_AND = 6'b100100;
   localparam logic [5:0] EXE_OR  = 6'b100101;
   localparam logic [5:0] EXE_XOR = 6'b100110;
   localparam logic [5:0] EXE_NOR = 6'b100111;
   localparam logic [5:0] EXE_SLL = 6'b000000;
   localparam logic [5:0] EXE_SRL = 6'b000010;
   localparam logic [5:0] EXE_SRA = 6'b000011;

   localparam logic [7:0] EXE_AND_OP = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
   localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP = 8'b00000011;
   localparam logic [7:0] EXE_NOP_OP = 8'b00000000;

   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

   localparam logic RstEnable    = 1'b1;
   localparam logic ReadEnable   = 1'b1;
   localparam logic ReadDisable  = 1'b0;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic InstValid    = 1'b1;
   localparam logic InstInvalid  = 1'b0;

   // SPECIAL funct -> aluop for the R-type logic and shift group
   function automatic logic [7:0] funct_aluop(input logic [5:0] funct);
      case (funct)
         EXE_AND: return EXE_AND_OP;
         EXE_OR:  return EXE_OR_OP;
         EXE_XOR: return EXE_XOR_OP;
         EXE_NOR: return EXE_NOR_OP;
         EXE_SLL: return EXE_SLL_OP;
         EXE_SRL: return EXE_SRL_OP;
         EXE_SRA: return EXE_SRA_OP;
         default: return EXE_NOP_OP;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_fwd_if.sv
// Instruction stream into the ID stage (from if_id) and decoded stream out of
// it (towards ex), both valid/ready.
//   master : pipeline side (drives in_valid/pc_i/inst_i and out_ready)
//   slave  : the ID stage (drives in_ready and the output register)
interface id_stage_fwd_if #(
   parameter int DATA_W   = 32,
   parameter int PC_W     = 32,
   parameter int REG_AW   = 5,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
);
   logic                in_valid;
   logic                in_ready;
   logic [PC_W-1:0]     pc_i;
   logic [31:0]         inst_i;

   logic                out_valid;
   logic                out_ready;
   logic [PC_W-1:0]     pc_o;
   logic [ALUOP_W-1:0]  aluop_o;
   logic [ALUSEL_W-1:0] alusel_o;
   logic [DATA_W-1:0]   reg1_o;
   logic [DATA_W-1:0]   reg2_o;
   logic [REG_AW-1:0]   wd_o;
   logic                wreg_o;
   logic                instvalid_o;

   modport master (
      output in_valid, pc_i, inst_i, out_ready,
      input  in_ready, out_valid, pc_o, aluop_o, alusel_o,
             reg1_o, reg2_o, wd_o, wreg_o, instvalid_o
   );

   modport slave (
      input  in_valid, pc_i, inst_i, out_ready,
      output in_ready, out_valid, pc_o, aluop_o, alusel_o,
             reg1_o, reg2_o, wd_o, wreg_o, instvalid_o
   );
endinterface

// File: rtl/id_stage_fwd_mux.sv
// Operand select for one source: immediate, hard zero for $0, EX bypass,
// MEM bypass, then regfile. EX is younger than MEM and so wins.
//   read_en/addr/imm : decoded source
//   rf_data          : regfile read data
//   ex_* / mem_*     : write-back bypass from EX and MEM
//   operand          : resolved value
module id_fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              read_en,
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_wreg,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              mem_wreg,
   input  logic [REG_AW-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] operand
);
   always_comb begin
      operand = rf_data;
      if (!read_en)
         operand = imm;
      else if (addr == '0)
         operand = '0;
      else if (ex_wreg && ex_wd == addr)
         operand = ex_wdata;
      else if (mem_wreg && mem_wd == addr)
         operand = mem_wdata;
   end
endmodule

// File: rtl/id_stage_fwd.sv
// openMIPS decode stage: decodes the logic/shift group, reads the regfile,
// forwards from EX/MEM, interlocks on load-use and registers the result into
// a valid/ready ID/EX output register with flush.
//   clk, rst        : clock, async active-high reset
//   bus (slave)     : in stream from if_id, out stream to ex
//   reg1/2_addr_o,
//   reg1/2_read_o   : regfile read port control (combinational on inst_i)
//   reg1/2_data_i   : regfile read data
//   ex_*, mem_*     : bypass; ex_is_load_i marks EX data as not yet valid
//   flush_i         : empty the output register
module id_stage_fwd
   import id_stage_fwd_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int PC_W     = 32,
   parameter int REG_AW   = 5,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   id_stage_fwd_if.slave     bus,
   output logic [REG_AW-1:0] reg1_addr_o,
   output logic [REG_AW-1:0] reg2_addr_o,
   output logic              reg1_read_o,
   output logic              reg2_read_o,
   input  logic [DATA_W-1:0] reg1_data_i,
   input  logic [DATA_W-1:0] reg2_data_i,
   input  logic              ex_wreg_i,
   input  logic [REG_AW-1:0] ex_wd_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_wreg_i,
   input  logic [REG_AW-1:0] mem_wd_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              flush_i
);
   logic [5:0]  op, funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [REG_AW-1:0] rs, rt, rd;

   assign op    = bus.inst_i[31:26];
   assign rs    = REG_AW'(bus.inst_i[25:21]);
   assign rt    = REG_AW'(bus.inst_i[20:16]);
   assign rd    = REG_AW'(bus.inst_i[15:11]);
   assign shamt = bus.inst_i[10:6];
   assign funct = bus.inst_i[5:0];
   assign imm   = bus.inst_i[15:0];

   logic [DATA_W-1:0]   imm1, imm2;
   logic [REG_AW-1:0]   dec_wd;
   logic                dec_wreg, dec_valid;
   logic [ALUOP_W-1:0]  dec_aluop;
   logic [ALUSEL_W-1:0] dec_alusel;

   always_comb begin
      reg1_read_o = ReadDisable;
      reg2_read_o = ReadDisable;
      imm1        = '0;
      imm2        = '0;
      dec_wd      = rd;
      dec_wreg    = WriteDisable;
      dec_aluop   = ALUOP_W'(EXE_NOP_OP);
      dec_alusel  = ALUSEL_W'(EXE_RES_NOP);
      dec_valid   = InstInvalid;
      case (op)
         EXE_ORI, EXE_ANDI, EXE_XORI, EXE_LUI: begin
            reg1_read_o = ReadEnable;
            imm2        = (op == EXE_LUI) ? DATA_W'({imm, 16'h0000}) : DATA_W'(imm);
            dec_wd      = rt;
            dec_wreg    = WriteEnable;
            dec_alusel  = ALUSEL_W'(EXE_RES_LOGIC);
            dec_valid   = InstValid;
            case (op)
               EXE_ANDI: dec_aluop = ALUOP_W'(EXE_AND_OP);
               EXE_XORI: dec_aluop = ALUOP_W'(EXE_XOR_OP);
               default:  dec_aluop = ALUOP_W'(EXE_OR_OP);
            endcase
         end
         EXE_SPECIAL: begin
            case (funct)
               EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                  if (shamt == 5'd0) begin
                     reg1_read_o = ReadEnable;
                     reg2_read_o = ReadEnable;
                     dec_wreg    = WriteEnable;
                     dec_aluop   = ALUOP_W'(funct_aluop(funct));
                     dec_alusel  = ALUSEL_W'(EXE_RES_LOGIC);
                     dec_valid   = InstValid;
                  end
               end
               EXE_SLL, EXE_SRL, EXE_SRA: begin
                  if (rs == '0) begin
                     imm1        = DATA_W'(shamt);
                     reg2_read_o = ReadEnable;
                     dec_wreg    = WriteEnable;
                     dec_aluop   = ALUOP_W'(funct_aluop(funct));
                     dec_alusel  = ALUSEL_W'(EXE_RES_SHIFT);
                     dec_valid   = InstValid;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign reg1_addr_o = rs;
   assign reg2_addr_o = rt;

   logic [DATA_W-1:0] opnd1, opnd2;

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux1 (
      .read_en(reg1_read_o), .addr(rs), .imm(imm1), .rf_data(reg1_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
      .operand(opnd1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux2 (
      .read_en(reg2_read_o), .addr(rt), .imm(imm2), .rf_data(reg2_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
      .operand(opnd2)
   );

   // Load in EX: its result only exists once it reaches MEM, so hold one cycle.
   logic stall, advance;
   assign stall = bus.in_valid && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                  ((reg1_read_o && rs == ex_wd_i) || (reg2_read_o && rt == ex_wd_i));
   assign advance = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = (rst != RstEnable) && (flush_i || (!stall && advance));

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         bus.out_valid   <= 1'b0;
         bus.pc_o        <= '0;
         bus.aluop_o     <= ALUOP_W'(EXE_NOP_OP);
         bus.alusel_o    <= ALUSEL_W'(EXE_RES_NOP);
         bus.reg1_o      <= '0;
         bus.reg2_o      <= '0;
         bus.wd_o        <= '0;
         bus.wreg_o      <= WriteDisable;
         bus.instvalid_o <= InstValid;
      end else if (flush_i) begin
         bus.out_valid <= 1'b0;
         bus.wreg_o    <= WriteDisable;
      end else if (advance) begin
         if (bus.in_valid && !stall) begin
            bus.out_valid   <= 1'b1;
            bus.pc_o        <= bus.pc_i;
            bus.aluop_o     <= dec_aluop;
            bus.alusel_o    <= dec_alusel;
            bus.reg1_o      <= opnd1;
            bus.reg2_o      <= opnd2;
            bus.wd_o        <= dec_wd;
            bus.wreg_o      <= dec_wreg;
            bus.instvalid_o <= dec_valid;
         end else begin
            // bubble: wreg_o is cleared so an empty slot never writes back
            bus.out_valid <= 1'b0;
            bus.wreg_o    <= WriteDisable;
         end
      end
   end
endmodule

// File: tb/tb_id_stage_fwd.sv
module tb_id_stage_fwd;
   import id_stage_fwd_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_stage_fwd_if #(.DATA_W(32), .PC_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3)) bus ();

   logic [4:0]  reg1_addr_o, reg2_addr_o;
   logic        reg1_read_o, reg2_read_o;
   logic [31:0] reg1_data_i, reg2_data_i;
   logic        ex_wreg_i, ex_is_load_i, mem_wreg_i, flush_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic [31:0] rf [0:31];

   assign reg1_data_i = rf[reg1_addr_o];
   assign reg2_data_i = rf[reg2_addr_o];

   id_stage_fwd #(.DATA_W(32), .PC_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .flush_i(flush_i)
   );

   int n_pass = 0;
   int n_total = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic        r1, r2;
      logic [4:0]  a1, a2, wd;
      logic [31:0] i1, i2;
      logic        wreg, iv;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
   } dec_t;

   function automatic dec_t ref_dec(input logic [31:0] w);
      dec_t d;
      logic [5:0] op, fn;
      op = w[31:26];
      fn = w[5:0];
      d.r1 = 0; d.r2 = 0; d.i1 = 0; d.i2 = 0; d.wreg = 0; d.iv = 0;
      d.a1 = w[25:21]; d.a2 = w[20:16]; d.wd = w[15:11];
      d.aluop = EXE_NOP_OP; d.alusel = EXE_RES_NOP;
      if (op == EXE_ORI || op == EXE_ANDI || op == EXE_XORI || op == EXE_LUI) begin
         d.r1 = 1; d.wd = w[20:16]; d.wreg = 1; d.iv = 1; d.alusel = EXE_RES_LOGIC;
         d.i2 = (op == EXE_LUI) ? {w[15:0], 16'h0} : {16'h0, w[15:0]};
         d.aluop = (op == EXE_ANDI) ? EXE_AND_OP : (op == EXE_XORI) ? EXE_XOR_OP : EXE_OR_OP;
      end else if (op == EXE_SPECIAL && w[10:6] == 0 &&
                   (fn == EXE_AND || fn == EXE_OR || fn == EXE_XOR || fn == EXE_NOR)) begin
         d.r1 = 1; d.r2 = 1; d.wreg = 1; d.iv = 1; d.alusel = EXE_RES_LOGIC;
         d.aluop = (fn == EXE_AND) ? EXE_AND_OP : (fn == EXE_OR) ? EXE_OR_OP :
                   (fn == EXE_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
      end else if (op == EXE_SPECIAL && w[25:21] == 0 &&
                   (fn == EXE_SLL || fn == EXE_SRL || fn == EXE_SRA)) begin
         d.r2 = 1; d.wreg = 1; d.iv = 1; d.alusel = EXE_RES_SHIFT;
         d.i1 = {27'h0, w[10:6]};
         d.aluop = (fn == EXE_SLL) ? EXE_SLL_OP : (fn == EXE_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
      end
      return d;
   endfunction

   function automatic logic [31:0] ref_opnd(input logic rd, input logic [4:0] a, input logic [31:0] imm);
      if (!rd) return imm;
      if (a == 0) return 32'h0;
      if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
      if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
      return rf[a];
   endfunction

   logic        exp_valid;
   logic [31:0] exp_pc, exp_r1, exp_r2;
   dec_t        exp_d;
   logic        exp_ir, obs_ir, exp_r1rd, exp_r2rd, obs_r1rd, obs_r2rd;

   // one clock with current inputs; model follows; no checking here
   task automatic tick();
      dec_t d;
      logic stall, adv;
      d = ref_dec(bus.inst_i);
      stall = bus.in_valid && ex_is_load_i && ex_wreg_i && ex_wd_i != 0 &&
              ((d.r1 && d.a1 == ex_wd_i) || (d.r2 && d.a2 == ex_wd_i));
      adv = !exp_valid || bus.out_ready;
      exp_ir = flush_i || (!stall && adv);
      exp_r1rd = d.r1;
      exp_r2rd = d.r2;
      @(negedge clk);
      obs_ir = bus.in_ready;
      obs_r1rd = reg1_read_o;
      obs_r2rd = reg2_read_o;
      if (flush_i) exp_valid = 0;
      else if (adv && bus.in_valid && !stall) begin
         exp_valid = 1; exp_pc = bus.pc_i; exp_d = d;
         exp_r1 = ref_opnd(d.r1, d.a1, d.i1);
         exp_r2 = ref_opnd(d.r2, d.a2, d.i2);
      end else if (adv) exp_valid = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.in_valid = 0; bus.out_ready = 1; flush_i = 0;
      ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
      mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
   endtask

   function automatic logic [31:0] rand_inst();
      int k;
      logic [4:0] rs, rt, rd, sh;
      k = $urandom_range(0, 11);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7)); sh = 5'($urandom);
      case (k)
         0: return {EXE_ORI, rs, rt, 16'($urandom)};
         1: return {EXE_ANDI, rs, rt, 16'($urandom)};
         2: return {EXE_XORI, rs, rt, 16'($urandom)};
         3: return {EXE_LUI, rs, rt, 16'($urandom)};
         4, 5, 6, 7: return {EXE_SPECIAL, rs, rt, rd,
                             ($urandom_range(0, 7) == 0) ? sh : 5'd0,
                             (k == 4) ? EXE_AND : (k == 5) ? EXE_OR : (k == 6) ? EXE_XOR : EXE_NOR};
         8, 9, 10: return {EXE_SPECIAL, ($urandom_range(0, 7) == 0) ? rs : 5'd0, rt, rd, sh,
                           (k == 8) ? EXE_SLL : (k == 9) ? EXE_SRL : EXE_SRA};
         default: return $urandom;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; quiet(); bus.pc_i = 0; bus.inst_i = 0; exp_valid = 0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      @(posedge clk); @(negedge clk);
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); else n_pass++;
      n_total++; if (bus.out_valid !== 1'b0 || bus.wreg_o !== 1'b0 || bus.instvalid_o !== 1'b1)
         $display("FAIL reset_flags got v=%b w=%b iv=%b exp 0 0 1", bus.out_valid, bus.wreg_o, bus.instvalid_o); else n_pass++;
      n_total++; if (bus.pc_o !== 0 || bus.reg1_o !== 0 || bus.reg2_o !== 0 || bus.wd_o !== 0)
         $display("FAIL reset_data got pc=%h r1=%h r2=%h wd=%h exp zeros", bus.pc_o, bus.reg1_o, bus.reg2_o, bus.wd_o); else n_pass++;
      n_total++; if (bus.aluop_o !== EXE_NOP_OP || bus.alusel_o !== EXE_RES_NOP)
         $display("FAIL reset_op got %h/%h exp %h/%h", bus.aluop_o, bus.alusel_o, EXE_NOP_OP, EXE_RES_NOP); else n_pass++;
      @(posedge clk); #1; rst = 0;
   endtask

   task automatic test_ori();
      quiet(); rf[0] = 32'hDEAD_BEEF;
      bus.in_valid = 1; bus.pc_i = 32'h100; bus.inst_i = {EXE_ORI, 5'd0, 5'd1, 16'h1100};
      tick();
      n_total++; if (obs_ir !== 1'b1) $display("FAIL ori_in_ready got %b exp 1", obs_ir); else n_pass++;
      n_total++; if (bus.out_valid !== 1 || bus.wd_o !== 5'd1 || bus.wreg_o !== 1 || bus.pc_o !== 32'h100)
         $display("FAIL ori_ctl got v=%b wd=%0d w=%b pc=%h exp 1 1 1 100", bus.out_valid, bus.wd_o, bus.wreg_o, bus.pc_o); else n_pass++;
      n_total++; if (bus.reg1_o !== 32'h0 || bus.reg2_o !== 32'h1100)
         $display("FAIL ori_opnd got %h %h exp 0 1100", bus.reg1_o, bus.reg2_o); else n_pass++;
      n_total++; if (bus.aluop_o !== EXE_OR_OP || bus.alusel_o !== EXE_RES_LOGIC)
         $display("FAIL ori_op got %h/%h exp %h/%h", bus.aluop_o, bus.alusel_o, EXE_OR_OP, EXE_RES_LOGIC); else n_pass++;
      bus.in_valid = 0; tick();
      n_total++; if (bus.out_valid !== 0 || bus.wreg_o !== 0)
         $display("FAIL idle_bubble got v=%b w=%b exp 0 0", bus.out_valid, bus.wreg_o); else n_pass++;
   endtask

   task automatic test_forward();
      quiet(); rf[1] = 32'h1111; rf[2] = 32'h0F;
      bus.in_valid = 1; bus.pc_i = 32'h104; bus.inst_i = {EXE_SPECIAL, 5'd1, 5'd2, 5'd3, 5'd0, EXE_OR};
      ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hA5;
      mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'h5A;
      tick();
      n_total++; if (bus.reg1_o !== 32'hA5 || bus.reg2_o !== 32'h0F || bus.wd_o !== 5'd3)
         $display("FAIL fwd_ex_prio got %h %h wd=%0d exp a5 0f 3", bus.reg1_o, bus.reg2_o, bus.wd_o); else n_pass++;
      ex_wreg_i = 0; mem_wd_i = 2; mem_wdata_i = 32'h0F; rf[2] = 32'h7777;
      tick();
      n_total++; if (bus.reg1_o !== 32'h1111 || bus.reg2_o !== 32'h0F)
         $display("FAIL fwd_mem got %h %h exp 1111 0f", bus.reg1_o, bus.reg2_o); else n_pass++;
   endtask

   task automatic test_load_use();
      quiet(); rf[4] = 32'h1234;
      bus.in_valid = 1; bus.pc_i = 32'h108; bus.inst_i = {EXE_SPECIAL, 5'd0, 5'd4, 5'd5, 5'd2, EXE_SRA};
      ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1; ex_wdata_i = 32'hBAD;
      tick();
      n_total++; if (obs_ir !== 1'b0) $display("FAIL lu_stall_in_ready got %b exp 0", obs_ir); else n_pass++;
      n_total++; if (bus.out_valid !== 0 || bus.wreg_o !== 0)
         $display("FAIL lu_bubble got v=%b w=%b exp 0 0", bus.out_valid, bus.wreg_o); else n_pass++;
      ex_wreg_i = 0; ex_is_load_i = 0; mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h8000_0000;
      tick();
      n_total++; if (obs_ir !== 1'b1) $display("FAIL lu_resume_in_ready got %b exp 1", obs_ir); else n_pass++;
      n_total++; if (bus.out_valid !== 1 || bus.reg2_o !== 32'h8000_0000 || bus.reg1_o !== 32'd2 ||
                     bus.aluop_o !== EXE_SRA_OP || bus.alusel_o !== EXE_RES_SHIFT || bus.wd_o !== 5'd5)
         $display("FAIL lu_sra got v=%b r1=%h r2=%h op=%h sel=%h wd=%0d exp 1 2 80000000 %h %h 5",
                  bus.out_valid, bus.reg1_o, bus.reg2_o, bus.aluop_o, bus.alusel_o, bus.wd_o, EXE_SRA_OP, EXE_RES_SHIFT);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      quiet(); rf[6] = 32'h1234_5678;
      bus.in_valid = 1; bus.pc_i = 32'h200; bus.inst_i = {EXE_ANDI, 5'd0, 5'd6, 16'h00F0};
      tick();
      bus.out_ready = 0; bus.pc_i = 32'h204; bus.inst_i = {EXE_XORI, 5'd6, 5'd7, 16'h0F0F};
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (obs_ir !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", i, obs_ir); else n_pass++;
         n_total++; if (bus.out_valid !== 1 || bus.pc_o !== 32'h200 || bus.reg2_o !== 32'hF0 ||
                        bus.wd_o !== 5'd6 || bus.aluop_o !== EXE_AND_OP || bus.reg1_o !== 32'h0)
            $display("FAIL bp_hold[%0d] got v=%b pc=%h r1=%h r2=%h wd=%0d op=%h exp 1 200 0 f0 6 %h",
                     i, bus.out_valid, bus.pc_o, bus.reg1_o, bus.reg2_o, bus.wd_o, bus.aluop_o, EXE_AND_OP);
         else n_pass++;
      end
      bus.out_ready = 1;
      tick();
      n_total++; if (obs_ir !== 1'b1) $display("FAIL bp_release_in_ready got %b exp 1", obs_ir); else n_pass++;
      n_total++; if (bus.pc_o !== 32'h204 || bus.reg1_o !== 32'h1234_5678 || bus.reg2_o !== 32'h0F0F ||
                     bus.wd_o !== 5'd7 || bus.aluop_o !== EXE_XOR_OP)
         $display("FAIL bp_next got pc=%h r1=%h r2=%h wd=%0d op=%h exp 204 12345678 f0f 7 %h",
                  bus.pc_o, bus.reg1_o, bus.reg2_o, bus.wd_o, bus.aluop_o, EXE_XOR_OP);
      else n_pass++;
   endtask

   task automatic test_flush();
      quiet();
      bus.in_valid = 1; bus.pc_i = 32'h300; bus.inst_i = {EXE_ORI, 5'd0, 5'd2, 16'h0042};
      tick();
      flush_i = 1; bus.out_ready = 0; bus.pc_i = 32'h304; bus.inst_i = {EXE_ORI, 5'd0, 5'd3, 16'h0043};
      tick();
      n_total++; if (obs_ir !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", obs_ir); else n_pass++;
      n_total++; if (bus.out_valid !== 0 || bus.wreg_o !== 0)
         $display("FAIL flush_drop got v=%b w=%b exp 0 0", bus.out_valid, bus.wreg_o); else n_pass++;
      flush_i = 0; bus.out_ready = 1; bus.pc_i = 32'h308; bus.inst_i = {EXE_ORI, 5'd0, 5'd1, 16'h0001};
      ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'hFF; ex_is_load_i = 1;
      mem_wreg_i = 1; mem_wd_i = 0; mem_wdata_i = 32'hEE;
      tick();
      n_total++; if (obs_ir !== 1'b1) $display("FAIL zero_no_stall got %b exp 1", obs_ir); else n_pass++;
      n_total++; if (bus.out_valid !== 1 || bus.reg1_o !== 32'h0 || bus.reg2_o !== 32'h1)
         $display("FAIL zero_reg got v=%b r1=%h r2=%h exp 1 0 1", bus.out_valid, bus.reg1_o, bus.reg2_o); else n_pass++;
   endtask

   task automatic test_illegal();
      quiet();
      bus.in_valid = 1; bus.pc_i = 32'h400; bus.inst_i = {6'h3F, 26'h0123456};
      tick();
      n_total++; if (obs_r1rd !== 0 || obs_r2rd !== 0)
         $display("FAIL ill_reads got %b %b exp 0 0", obs_r1rd, obs_r2rd); else n_pass++;
      n_total++; if (bus.out_valid !== 1 || bus.instvalid_o !== 0 || bus.wreg_o !== 0 || bus.pc_o !== 32'h400 ||
                     bus.aluop_o !== EXE_NOP_OP || bus.alusel_o !== EXE_RES_NOP)
         $display("FAIL ill_out got v=%b iv=%b w=%b pc=%h op=%h sel=%h exp 1 0 0 400 0 0",
                  bus.out_valid, bus.instvalid_o, bus.wreg_o, bus.pc_o, bus.aluop_o, bus.alusel_o);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      quiet();
      bus.in_valid = 1; bus.pc_i = 32'h500; bus.inst_i = {EXE_LUI, 5'd0, 5'd9, 16'hABCD};
      tick();
      n_total++; if (bus.out_valid !== 1 || bus.reg2_o !== 32'hABCD_0000)
         $display("FAIL lui got v=%b r2=%h exp 1 abcd0000", bus.out_valid, bus.reg2_o); else n_pass++;
      #2 rst = 1;
      #1;
      n_total++; if (bus.in_ready !== 0 || bus.out_valid !== 0 || bus.wreg_o !== 0 || bus.pc_o !== 0 ||
                     bus.reg1_o !== 0 || bus.reg2_o !== 0 || bus.wd_o !== 0 || bus.instvalid_o !== 1 ||
                     bus.aluop_o !== EXE_NOP_OP || bus.alusel_o !== EXE_RES_NOP)
         $display("FAIL async_rst got rdy=%b v=%b w=%b pc=%h r1=%h r2=%h wd=%0d iv=%b op=%h sel=%h exp reset values",
                  bus.in_ready, bus.out_valid, bus.wreg_o, bus.pc_o, bus.reg1_o, bus.reg2_o, bus.wd_o,
                  bus.instvalid_o, bus.aluop_o, bus.alusel_o);
      else n_pass++;
      exp_valid = 0;
      @(posedge clk); #1; rst = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = ($urandom_range(0, 4) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush_i       = ($urandom_range(0, 15) == 0);
         bus.pc_i      = $urandom;
         bus.inst_i    = rand_inst();
         ex_wreg_i     = $urandom_range(0, 1);
         ex_wd_i       = 5'($urandom_range(0, 7));
         ex_wdata_i    = $urandom;
         ex_is_load_i  = ($urandom_range(0, 3) == 0);
         mem_wreg_i    = $urandom_range(0, 1);
         mem_wd_i      = 5'($urandom_range(0, 7));
         mem_wdata_i   = $urandom;
         tick();
         n_total++; if (obs_ir !== exp_ir || obs_r1rd !== exp_r1rd || obs_r2rd !== exp_r2rd)
            $display("FAIL rnd_ctl[%0d] got rdy=%b rd=%b%b exp %b %b%b", n, obs_ir, obs_r1rd, obs_r2rd,
                     exp_ir, exp_r1rd, exp_r2rd);
         else n_pass++;
         n_total++; if (bus.out_valid !== exp_valid || bus.wreg_o !== (exp_valid & exp_d.wreg))
            $display("FAIL rnd_valid[%0d] got v=%b w=%b exp %b %b", n, bus.out_valid, bus.wreg_o,
                     exp_valid, exp_valid & exp_d.wreg);
         else n_pass++;
         if (exp_valid) begin
            n_total++;
            if (bus.pc_o !== exp_pc || bus.aluop_o !== exp_d.aluop || bus.alusel_o !== exp_d.alusel ||
                bus.instvalid_o !== exp_d.iv || (exp_d.wreg && bus.wd_o !== exp_d.wd) ||
                (exp_d.iv && (bus.reg1_o !== exp_r1 || bus.reg2_o !== exp_r2)))
               $display("FAIL rnd_payload[%0d] got pc=%h op=%h sel=%h iv=%b wd=%0d r1=%h r2=%h exp %h %h %h %b %0d %h %h",
                        n, bus.pc_o, bus.aluop_o, bus.alusel_o, bus.instvalid_o, bus.wd_o, bus.reg1_o, bus.reg2_o,
                        exp_pc, exp_d.aluop, exp_d.alusel, exp_d.iv, exp_d.wd, exp_r1, exp_r2);
            else n_pass++;
         end
      end
      quiet();
      tick();
   endtask

   initial begin
      test_reset();
      test_ori();
      test_forward();
      test_load_use();
      test_backpressure();
      test_flush();
      test_illegal();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
